// File: rtl/traceback.sv
// traceback
//   Traceback unit for a 4-state (K=3, rate-1/2) Viterbi decoder. Walks the
//   survivor path through the per-stage previous-state pointers, which arrive
//   newest stage first. It recovers one decoded bit per stage and emits one
//   N_STAGE-bit word per frame.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   en_traceback           frame enable (low aborts a frame or releases DONE)
//   i_valid                pointer inputs carry a new stage this cycle
//   i_start_st             start state, sampled on the first beat of a frame
//   i_bck_prv_st_00..11    previous-state pointer for each state
//   o_data                 decoded frame, bit t = decoded bit of stage t
//   o_valid                one-cycle pulse when o_data/o_term_ok update
//   o_busy                 high while tracing
//   o_term_ok              final traced state was 2'b00
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// TRACE | accepting beats, following the survivor path
// DONE  | frame emitted; repeated stage-0 beats ignored until enable drops
module traceback #(
  parameter int N_STAGE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_traceback,
  input  logic               i_valid,
  input  logic [1:0]         i_start_st,
  input  logic [1:0]         i_bck_prv_st_00,
  input  logic [1:0]         i_bck_prv_st_01,
  input  logic [1:0]         i_bck_prv_st_10,
  input  logic [1:0]         i_bck_prv_st_11,
  output logic [N_STAGE-1:0] o_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_term_ok
);

  localparam int CW = $clog2(N_STAGE) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_STAGE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         cur_st_q, cur_st_d;
  logic [N_STAGE-1:0] shadow_q, shadow_d;
  logic [N_STAGE-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               term_q, term_d;

  // The first beat is taken straight from IDLE, so the working state and
  // count come from the start input / zero rather than from the registers.
  logic               in_idle;
  logic [1:0]         st_use;
  logic [CW-1:0]      cnt_use;
  logic [N_STAGE-1:0] shadow_base;
  logic [N_STAGE-1:0] shadow_new;
  logic [CW-1:0]      bit_idx;
  logic [1:0]         ptr_sel;
  logic               accept;

  always_comb begin
    in_idle     = (state_q == IDLE);
    st_use      = in_idle ? i_start_st : cur_st_q;
    cnt_use     = in_idle ? '0 : cnt_q;
    shadow_base = in_idle ? '0 : shadow_q;
    bit_idx     = LAST - cnt_use;
    shadow_new  = shadow_base | ({{(N_STAGE-1){1'b0}}, st_use[1]} << bit_idx);
    accept      = en_traceback & i_valid & (state_q != DONE);

    unique case (st_use)
      2'b00:   ptr_sel = i_bck_prv_st_00;
      2'b01:   ptr_sel = i_bck_prv_st_01;
      2'b10:   ptr_sel = i_bck_prv_st_10;
      default: ptr_sel = i_bck_prv_st_11;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_st_d = cur_st_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    term_d   = term_q;
    valid_d  = 1'b0;

    if (!en_traceback) begin
      // Abort/release: an in-flight beat is discarded, outputs keep their values.
      state_d  = IDLE;
      cnt_d    = '0;
      cur_st_d = 2'b00;
      shadow_d = '0;
    end else if (accept) begin
      cur_st_d = ptr_sel;
      if (cnt_use == LAST) begin
        data_d   = shadow_new;
        term_d   = (ptr_sel == 2'b00);
        valid_d  = 1'b1;
        state_d  = DONE;
        cnt_d    = '0;
        shadow_d = '0;
      end else begin
        cnt_d    = cnt_use + 1'b1;
        shadow_d = shadow_new;
        state_d  = TRACE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_st_q <= 2'b00;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      term_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_st_q <= cur_st_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      term_q   <= term_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_term_ok = term_q;
  assign o_busy    = (state_q == TRACE);

endmodule

// File: doc/traceback.md
# traceback

Traceback unit for the 4-state (K=3, rate-1/2) Viterbi decoder. It sits directly downstream of the survivor-path memory. It consumes that memory's per-stage previous-state pointers, which arrive newest stage first (stage 7 down to stage 0). It follows the survivor path from a given start state, recovers one decoded bit per stage, and emits one 8-bit decoded word per frame with a single-cycle valid strobe.

## Interface
- `N_STAGE`, 8, trellis stages per frame and width of `o_data`. The counter is `$clog2(N_STAGE)+1` bits wide.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en_traceback`  in  1  frame enable.
  - Held high for the whole frame.
  - Dropping it aborts or releases the frame.
- `i_valid`  in  1  the four pointer inputs hold a new stage this cycle.
- `i_start_st`  in  2  state the traceback starts from. Sampled only on the first accepted beat of a frame.
- `i_bck_prv_st_00`, `i_bck_prv_st_01`, `i_bck_prv_st_10`, `i_bck_prv_st_11`  in  2 each  previous-state pointer for the named state at the current stage.
- `o_data`  out  N_STAGE  decoded frame; bit t is the decoded bit of stage t.
- `o_valid`  out  1  one-cycle pulse when `o_data` is updated.
- `o_busy`  out  1  high while in TRACE.
- `o_term_ok`  out  1  the final traced state equals 2'b00 (zero-tail termination met). Updated together with `o_data`.

## Operation
- State encoding is s = {u_t, u_(t-1)}.
  - The decoded bit of a stage is cur_st[1].
  - The next state is the pointer selected by cur_st.
- FSM states and transitions:
  - IDLE → TRACE: on `en_traceback` & `i_valid`. This beat is processed as stage N_STAGE-1, using `i_start_st` as cur_st.
  - TRACE: each cycle with `i_valid` = 1 is one accepted beat. cnt = number of beats already accepted.
    - Write bit[N_STAGE-1-cnt] of the shadow register with cur_st[1].
    - Set cur_st to ptr[cur_st].
    - Increment cnt.
  - TRACE, `i_valid` = 0: stall; hold all state.
  - TRACE → DONE: on the N_STAGE-th accepted beat.
    - Copy the shadow register into `o_data`.
    - Set `o_term_ok` = (next cur_st == 2'b00).
    - Pulse `o_valid`.
  - DONE: `i_valid` is ignored. The upstream memory keeps presenting stage 0, and those repeats must not be consumed.
  - DONE → IDLE: when `en_traceback` = 0.
  - Any state → IDLE: `en_traceback` = 0 in TRACE aborts. cnt and the shadow register are cleared, no `o_valid` is produced, and `o_data`/`o_term_ok` keep their previous values.
- Pointer mux: index 0 → `_00`, 1 → `_01`, 2 → `_10`, 3 → `_11`.

## Timing
- Reset values:
  - FSM IDLE.
  - cnt = 0, cur_st = 2'b00, shadow register = 0.
  - `o_data` = 0, `o_valid` = 0, `o_busy` = 0, `o_term_ok` = 0.
- Reset mid-frame behaves exactly like the power-up reset; no output pulse.
- Inputs are sampled on the rising edge.
- `o_data`, `o_term_ok` and `o_valid` are registered. They change on the same edge that accepts the final beat, so there is 0 cycles of extra latency after that edge.
- `o_valid` is high for exactly one cycle per completed frame and is never asserted in IDLE or TRACE.
- Minimum frame: N_STAGE consecutive valid cycles, then 1 cycle with `en_traceback` low, before a new frame can start.
- `o_busy` is high from the edge after the first accepted beat until the edge that completes the frame.
- Simultaneous `en_traceback` = 0 and `i_valid` = 1 in TRACE: the abort wins and the beat is discarded.

## Test plan
- Message 1,0,1,1,0,0,0,0 with start 00. Per-stage pointers for the traced state, stage 7→0: 00,00,01,11,10,01,10,00; all other pointers 11. → `o_data` = 8'h0D, `o_term_ok` = 1, one `o_valid` pulse 8 cycles after the first beat.
- Same frame with `i_valid` deasserted for 3 cycles between stages 4 and 3 → identical result, `o_valid` arrives 3 cycles later.
- All pointers 11 and start 11 → `o_data` = 8'hFF, `o_term_ok` = 0.
- After `o_valid`, hold `en_traceback` high with `i_valid` = 1 for 5 more cycles → no further `o_valid`, `o_data` stable. Drop and raise `en_traceback`, run a second frame → new result.
- Drop `en_traceback` after 4 beats → no `o_valid`, `o_data` keeps its prior value. The next full frame decodes correctly.
- Assert `rst` after 5 beats → every output reads 0 immediately (asynchronous). A subsequent full frame decodes 8'h0D.
